// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART types: frame mode encoding, TX scheduler state
//             encoding and the mode normalisation helper.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Field widths shared by the TX scheduler and the serializer datapath
    localparam int c_BYTE_W = 8;
    localparam int c_MODE_W = 2;

    // Frame mode as understood by both the transmitter and the receiver
    typedef enum logic [1:0] {
        MODE_8N1 = 2'b00,
        MODE_8E1 = 2'b01,
        MODE_8O1 = 2'b11
    } mode_t;

    // Scheduler FSM encoding; 2'b11 is unused and recovers to idle
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LAUNCH = 2'b01,
        S_WAIT   = 2'b10
    } sched_state_t;

    // The reserved code 2'b10 is sent as plain 8N1 so the serializer never
    // sees an undefined framing request.
    function automatic mode_t normalize_mode(input logic [1:0] i_mode);
        mode_t v_mode;
        case (i_mode)
            2'b01:   v_mode = MODE_8E1;
            2'b11:   v_mode = MODE_8O1;
            default: v_mode = MODE_8N1;
        endcase
        return v_mode;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin arbiter. The pointer names the
//             highest-priority requester; the search wraps modulo N_REQ.
//             Returns a one-hot grant, the winner index and a valid flag.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Walk from the pointer upward with wrap and keep the first request seen
    always_comb begin
        logic [IDX_W-1:0] w_pos;
        w_pos   = '0;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int w_off = 0; w_off < N_REQ; w_off++) begin
            w_pos = IDX_W'((int'(i_ptr) + w_off) % N_REQ);
            if (!o_valid && i_req[w_pos]) begin
                o_valid      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_sched
//  Brief    : Shares one UART TX serializer between N_REQ byte producers.
//             Round-robin arbitration, data/mode latched at grant, one-cycle
//             start pulse, completion supervised by a timeout watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [N_REQ-1:0]             REQ,
    input  logic [c_BYTE_W*N_REQ-1:0]    REQ_DATA,
    input  logic [c_MODE_W*N_REQ-1:0]    REQ_MODE,
    output logic [N_REQ-1:0]             GNT,
    output logic [N_REQ-1:0]             ACK,
    output logic                         ERR,
    output logic                         TX_START,
    output logic [c_BYTE_W-1:0]          TX_DATA,
    output logic [c_MODE_W-1:0]          TX_MODE,
    input  logic                         TX_BUSY,
    input  logic                         TX_DONE
);

    localparam int                 c_IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int                 c_TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX  = c_TMR_W'(TIMEOUT);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_REQ - 1);

    sched_state_t         r_state;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_TMR_W-1:0]   r_timer;
    logic [N_REQ-1:0]     r_gnt;
    logic [N_REQ-1:0]     r_ack;
    logic                 r_err;
    logic                 r_tx_start;
    logic [c_BYTE_W-1:0]  r_tx_data;
    mode_t                r_tx_mode;

    logic [N_REQ-1:0]     w_arb_gnt;
    logic [c_IDX_W-1:0]   w_arb_idx;
    logic                 w_arb_valid;
    logic [c_TMR_W-1:0]   w_timer_inc;
    logic [c_IDX_W-1:0]   w_ptr_next;
    logic                 w_finish;

    logic [c_BYTE_W-1:0]  w_req_data [N_REQ];
    logic [c_MODE_W-1:0]  w_req_mode [N_REQ];

    // Split the flat request buses into per-requester fields
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_req_data[gi] = REQ_DATA[c_BYTE_W*gi +: c_BYTE_W];
        assign w_req_mode[gi] = REQ_MODE[c_MODE_W*gi +: c_MODE_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .i_req   (REQ),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // Saturating watchdog step; the frame aborts on the edge where the
    // incremented value reaches TIMEOUT, i.e. TIMEOUT edges after start.
    assign w_timer_inc = (r_timer == c_TMR_MAX) ? r_timer : r_timer + c_TMR_W'(1);

    // After a completion the requester just served drops to lowest priority
    assign w_ptr_next  = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);

    // A frame ends on TX_DONE or on watchdog expiry; TX_DONE wins a tie
    assign w_finish    = TX_DONE || (w_timer_inc == c_TMR_MAX);

    // Scheduler FSM with all outputs registered; pulses default low each cycle
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_timer    <= '0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_tx_mode  <= MODE_8N1;
        end else begin
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_arb_valid) begin
                        r_gnt     <= w_arb_gnt;
                        r_idx     <= w_arb_idx;
                        r_tx_data <= w_req_data[w_arb_idx];
                        r_tx_mode <= normalize_mode(w_req_mode[w_arb_idx]);
                        r_state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // Grant and latched byte are held while the serializer drains
                    if (!TX_BUSY) begin
                        r_tx_start <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_timer <= w_timer_inc;
                    if (w_finish) begin
                        r_ack   <= r_gnt;
                        r_err   <= !TX_DONE;
                        r_gnt   <= '0;
                        r_ptr   <= w_ptr_next;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign GNT      = r_gnt;
    assign ACK      = r_ack;
    assign ERR      = r_err;
    assign TX_START = r_tx_start;
    assign TX_DATA  = r_tx_data;
    assign TX_MODE  = r_tx_mode;

endmodule : uart_tx_sched
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_sched
//  Brief    : Self-checking bench for uart_tx_sched. One instance with a long
//             watchdog for the general traffic, one with TIMEOUT=8 for the
//             abort cases. Vector table, hand sequences and random frames
//             checked against a transaction-level round-robin model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int c_N    = 4;
    localparam int c_TO_M = 32;
    localparam int c_TO_T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_mode;
    logic        tx_busy;
    logic        tx_done;

    logic [3:0]  gnt_m, ack_m, gnt_t, ack_t;
    logic        err_m, err_t, start_m, start_t;
    logic [7:0]  txd_m, txd_t;
    logic [1:0]  txm_m, txm_t;

    // sel picks which instance the checks observe
    logic        sel;
    logic [3:0]  gnt, ack;
    logic        err, start;
    logic [7:0]  txd;
    logic [1:0]  txm;

    assign gnt   = sel ? gnt_t   : gnt_m;
    assign ack   = sel ? ack_t   : ack_m;
    assign err   = sel ? err_t   : err_m;
    assign start = sel ? start_t : start_m;
    assign txd   = sel ? txd_t   : txd_m;
    assign txm   = sel ? txm_t   : txm_m;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(.N_REQ(c_N), .TIMEOUT(c_TO_M)) dut_m (
        .CLK(clk), .RST(rst), .REQ(req), .REQ_DATA(req_data), .REQ_MODE(req_mode),
        .GNT(gnt_m), .ACK(ack_m), .ERR(err_m), .TX_START(start_m),
        .TX_DATA(txd_m), .TX_MODE(txm_m), .TX_BUSY(tx_busy), .TX_DONE(tx_done)
    );

    uart_tx_sched #(.N_REQ(c_N), .TIMEOUT(c_TO_T)) dut_t (
        .CLK(clk), .RST(rst), .REQ(req), .REQ_DATA(req_data), .REQ_MODE(req_mode),
        .GNT(gnt_t), .ACK(ack_t), .ERR(err_t), .TX_START(start_t),
        .TX_DATA(txd_t), .TX_MODE(txm_t), .TX_BUSY(tx_busy), .TX_DONE(tx_done)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [7:0]  mode;
        int          busy;
        int          done_at;
        logic        stray;
        int          exp_idx;
        logic [7:0]  exp_data;
        logic [1:0]  exp_mode;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    // Reference model state for the random phase
    logic [3:0] pend;
    logic [7:0] mdat [4];
    logic [1:0] mmod [4];
    int         mptr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        req      = '0;
        req_data = '0;
        req_mode = '0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // One frame from idle: grant edge, busy hold, start edge, then completion
    // at done_at edges after start (or at the watchdog limit when exp_err).
    task automatic run_frame(input int idx, input logic [7:0] edata, input logic [1:0] emode,
                             input int busy, input int done_at, input logic eerr,
                             input logic stray, input logic drop);
        int          limit;
        int          ack_at;
        logic [31:0] one;
        limit   = sel ? c_TO_T : c_TO_M;
        ack_at  = eerr ? limit : done_at;
        one     = 32'd1 << idx;
        tx_busy = (busy > 0);
        tx_done = stray;
        tick();
        check("grant",         32'(gnt),   one);
        check("data_at_grant", 32'(txd),   32'(edata));
        check("mode_at_grant", 32'(txm),   32'(emode));
        check("start_early",   32'(start), 32'd0);
        check("ack_at_grant",  32'(ack),   32'd0);
        for (int i = 0; i < busy; i++) begin
            req_data = $urandom();
            tick();
            check("start_while_busy", 32'(start), 32'd0);
            check("data_while_busy",  32'(txd),   32'(edata));
            check("gnt_while_busy",   32'(gnt),   one);
            if (i == busy - 1) tx_busy = 1'b0;
        end
        tick();
        check("tx_start", 32'(start), 32'd1);
        tx_done = 1'b0;
        if (drop) req = req & ~one[3:0];
        for (int j = 1; j <= ack_at; j++) begin
            tx_done = (j == done_at);
            tick();
            tx_done = 1'b0;
            if (j < ack_at) begin
                check("ack_early", 32'(ack), 32'd0);
                check("gnt_held",  32'(gnt), one);
                if (j == 1) check("start_one_cycle", 32'(start), 32'd0);
            end else begin
                check("ack",        32'(ack),   one);
                check("err",        32'(err),   32'(eerr));
                check("gnt_clear",  32'(gnt),   32'd0);
                check("start_late", 32'(start), 32'd0);
            end
        end
    endtask

    task automatic new_req(input int i);
        pend[i] = 1'b1;
        mdat[i] = 8'($urandom());
        mmod[i] = 2'($urandom());
    endtask

    initial begin
        rst      = 1'b0;
        sel      = 1'b0;
        req      = '0;
        req_data = '0;
        req_mode = '0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;

        // Reset values
        do_reset();
        check("rst_gnt",   32'(gnt_m),   32'd0);
        check("rst_ack",   32'(ack_m),   32'd0);
        check("rst_err",   32'(err_m),   32'd0);
        check("rst_start", 32'(start_m), 32'd0);
        check("rst_data",  32'(txd_m),   32'd0);
        check("rst_mode",  32'(txm_m),   32'd0);
        check("rst_gnt_t", 32'(gnt_t),   32'd0);

        // Vector table: each entry starts from reset, so the pointer is 0
        vecs[0] = '{4'b0010, 32'h0000_A500, 8'h04, 0, 18, 1'b0, 1, 8'hA5, 2'b01, 1'b0};
        vecs[1] = '{4'b1000, 32'h3C00_0000, 8'hC0, 5,  4, 1'b0, 3, 8'h3C, 2'b11, 1'b0};
        vecs[2] = '{4'b0110, 32'h007E_8100, 8'h18, 1,  1, 1'b1, 1, 8'h81, 2'b00, 1'b0};
        vecs[3] = '{4'b1100, 32'hF00F_0000, 8'h70, 0, 32, 1'b0, 2, 8'h0F, 2'b11, 1'b0};
        vecs[4] = '{4'b0001, 32'h0000_005A, 8'h00, 0,  0, 1'b1, 0, 8'h5A, 2'b00, 1'b1};
        vecs[5] = '{4'b0101, 32'h0066_0099, 8'h31, 2,  0, 1'b0, 0, 8'h99, 2'b01, 1'b1};
        sel = 1'b0;
        for (int v = 0; v < 6; v++) begin
            do_reset();
            req      = vecs[v].req;
            req_data = vecs[v].data;
            req_mode = vecs[v].mode;
            run_frame(vecs[v].exp_idx, vecs[v].exp_data, vecs[v].exp_mode, vecs[v].busy,
                      vecs[v].done_at, vecs[v].exp_err, vecs[v].stray, 1'b0);
            req = '0;
            tick();
            check("post_gnt", 32'(gnt), 32'd0);
            check("post_ack", 32'(ack), 32'd0);
            check("post_err", 32'(err), 32'd0);
        end

        // All four requesting continuously: order 0,1,2,3,0
        do_reset();
        req      = 4'b1111;
        req_data = 32'h4433_2211;
        req_mode = 8'h00;
        for (int g = 0; g < 5; g++) begin
            run_frame(g % 4, 8'(8'h11 * ((g % 4) + 1)), 2'b00, 0, 2 + g, 1'b0, 1'b0, 1'b0);
        end

        // Reset while waiting for completion
        do_reset();
        req      = 4'b0001;
        req_data = 32'h0000_00C3;
        run_frame(0, 8'hC3, 2'b00, 0, 3, 1'b0, 1'b0, 1'b0);
        req      = 4'b0010;
        req_data = 32'h0000_5AC3;
        tick();
        check("pre_rst_grant", 32'(gnt), 32'd2);
        tick();
        check("pre_rst_start", 32'(start), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        req = 4'b0011;
        tick();
        check("midrst_gnt",   32'(gnt),   32'd0);
        check("midrst_ack",   32'(ack),   32'd0);
        check("midrst_err",   32'(err),   32'd0);
        check("midrst_start", 32'(start), 32'd0);
        check("midrst_data",  32'(txd),   32'd0);
        check("midrst_mode",  32'(txm),   32'd0);
        rst     = 1'b1;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("postrst_no_ack", 32'(ack), 32'd0);
        check("postrst_ptr0",   32'(gnt), 32'd1);
        check("postrst_data",   32'(txd), 32'hC3);
        tick();
        check("postrst_no_ack2", 32'(ack),   32'd0);
        check("postrst_start",   32'(start), 32'd1);

        // Watchdog instance: abort, then late done ignored, then tie
        sel = 1'b1;
        do_reset();
        req      = 4'b0100;
        req_data = 32'h00E7_0000;
        req_mode = 8'h20;
        run_frame(2, 8'hE7, 2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
        run_frame(2, 8'hE7, 2'b00, 0, c_TO_T, 1'b0, 1'b1, 1'b0);
        req = '0;
        tick();
        check("to_post_err", 32'(err), 32'd0);
        check("to_post_gnt", 32'(gnt), 32'd0);

        // Random traffic against the round-robin model
        sel = 1'b0;
        do_reset();
        mptr = 0;
        pend = '0;
        for (int f = 0; f < 60; f++) begin
            int         w;
            int         busy;
            int         done_at;
            logic       ee;
            logic       st;
            logic       dr;
            logic [1:0] em;
            for (int i = 0; i < c_N; i++) begin
                if (!pend[i] && ($urandom_range(1, 0) == 1)) new_req(i);
            end
            if (pend == 4'b0000) begin
                req = '0;
                tick();
                check("rand_idle_gnt", 32'(gnt), 32'd0);
                new_req(int'($urandom_range(3, 0)));
            end
            req = pend;
            for (int i = 0; i < c_N; i++) begin
                req_data[8*i +: 8] = mdat[i];
                req_mode[2*i +: 2] = mmod[i];
            end
            w = -1;
            for (int k = 0; k < c_N; k++) begin
                if (w < 0 && pend[(mptr + k) % c_N]) w = (mptr + k) % c_N;
            end
            em      = (mmod[w] == 2'b10) ? 2'b00 : mmod[w];
            busy    = int'($urandom_range(3, 0));
            ee      = ($urandom_range(4, 0) == 0);
            done_at = ee ? 0 : int'($urandom_range(c_TO_M, 1));
            st      = ($urandom_range(2, 0) == 0);
            dr      = ($urandom_range(3, 0) == 0);
            run_frame(w, mdat[w], em, busy, done_at, ee, st, dr);
            mptr    = (w + 1) % c_N;
            pend[w] = 1'b0;
            if ($urandom_range(1, 0) == 1) new_req(w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_sched
`default_nettype wire
